// File: rtl/multdiv_stall_controller.sv
// Multiply/divide sequencer: launches the multi-cycle unit from execute, freezes the
// front end while it runs, and arbitrates the result write against the MW stage.
module multdiv_stall_controller #(
  parameter int unsigned MAX_CYCLES    = 40,
  parameter int unsigned CNT_W         = 6,
  parameter int unsigned RSTATUS_REG   = 30,
  parameter int unsigned MULT_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_ir,
  input  logic [31:0] x_operand_a,
  input  logic [31:0] x_operand_b,
  input  logic        flush,
  input  logic        mw_regwrite,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_WB
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic [4:0]        rd_q, rd_d;
  logic              is_div_q, is_div_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_en_q, wb_en_d;

  logic              dec_mult, dec_div;
  logic              stall_c, wb_valid_c;
  logic [31:0]       exc_code;

  assign dec_mult = (x_ir[31:27] == 5'b00000) && (x_ir[6:2] == 5'b00110);
  assign dec_div  = (x_ir[31:27] == 5'b00000) && (x_ir[6:2] == 5'b00111);
  assign exc_code = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rd_d         = rd_q;
    is_div_d     = is_div_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_en_d      = wb_en_q;
    stall_c      = 1'b0;
    wb_valid_c   = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((dec_mult || dec_div) && !flush) begin
          stall_c  = 1'b1;
          opa_d    = x_operand_a;
          opb_d    = x_operand_b;
          rd_d     = x_ir[26:22];
          is_div_d = dec_div;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        stall_c      = 1'b1;
        md_ctrl_mult = !is_div_q;
        md_ctrl_div  = is_div_q;
        cnt_d        = '0;
        state_d      = ST_BUSY;
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // A result arriving on the last allowed cycle wins over the timeout.
        if (md_ready && !md_exception) begin
          wb_rd_d   = rd_q;
          wb_data_d = md_result;
          wb_en_d   = (rd_q != 5'd0);
          state_d   = ST_WB;
        end else if (md_ready || (cnt_q == CNT_W'(MAX_CYCLES - 1))) begin
          wb_rd_d   = 5'(RSTATUS_REG);
          wb_data_d = exc_code;
          wb_en_d   = 1'b1;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        if (mw_regwrite) begin
          stall_c = 1'b1;
        end else begin
          wb_valid_c = wb_en_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
    end
  end

  // The IDLE stall is combinational from x_ir, so it is masked while reset is held.
  assign stall        = stall_c & reset;
  assign wb_valid     = wb_valid_c;
  assign wb_rd        = wb_valid_c ? wb_rd_q : '0;
  assign wb_data      = wb_valid_c ? wb_data_q : '0;
  assign md_operand_a = opa_q;
  assign md_operand_b = opb_q;

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// Randomized bench for multdiv_stall_controller: each operation is predicted at the
// transaction level (launch, pulse, busy window, held WB, final write).
module tb_multdiv_stall_controller;

  localparam int unsigned MAX_CYCLES = 40;

  logic        clock;
  logic        reset;
  logic [31:0] x_ir;
  logic [31:0] x_operand_a;
  logic [31:0] x_operand_b;
  logic        flush;
  logic        mw_regwrite;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int unsigned n_checks;
  int unsigned n_errors;

  multdiv_stall_controller #(
    .MAX_CYCLES   (MAX_CYCLES),
    .CNT_W        (6),
    .RSTATUS_REG  (30),
    .MULT_EXC_CODE(4),
    .DIV_EXC_CODE (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .x_ir        (x_ir),
    .x_operand_a (x_operand_a),
    .x_operand_b (x_operand_b),
    .flush       (flush),
    .mw_regwrite (mw_regwrite),
    .md_ready    (md_ready),
    .md_exception(md_exception),
    .md_result   (md_result),
    .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div (md_ctrl_div),
    .md_operand_a(md_operand_a),
    .md_operand_b(md_operand_b),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_md(input bit is_div, input logic [4:0] rd);
    logic [31:0] ir;
    ir        = $urandom;
    ir[31:27] = 5'b00000;
    ir[26:22] = rd;
    ir[6:2]   = is_div ? 5'b00111 : 5'b00110;
    return ir;
  endfunction

  function automatic logic [31:0] mk_other();
    logic [31:0] ir;
    ir = $urandom;
    if (ir[31:27] == 5'b00000 && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111))
      ir[31] = 1'b1;
    return ir;
  endfunction

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 2ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_mult"}, 32'(md_ctrl_mult), 32'd0);
    check({tag, "_div"}, 32'(md_ctrl_div), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
  endtask

  task automatic idle_cycle();
    tick();
    x_ir        = mk_other();
    flush       = $urandom_range(0, 1);
    mw_regwrite = $urandom_range(0, 1);
    md_ready    = 1'b0;
    #2;
    check_idle("idle");
  endtask

  // One complete operation: launch, START pulse, busy window of lat cycles (timeout above
  // MAX_CYCLES), hold WB for 'hold' MW writes, then the controller's own write.
  task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int unsigned lat, input bit exc,
                       input logic [31:0] res, input int unsigned hold);
    bit          timeout;
    int unsigned nbusy;
    logic        exp_v;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    timeout = (lat > MAX_CYCLES);
    nbusy   = timeout ? MAX_CYCLES : lat;

    tick();
    x_ir        = mk_md(is_div, rd);
    x_operand_a = a;
    x_operand_b = b;
    flush       = 1'b0;
    mw_regwrite = $urandom_range(0, 1);
    md_ready    = 1'b0;
    #2;
    check("launch_stall", 32'(stall), 32'd1);
    check("launch_nopulse", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    check("launch_wbv", 32'(wb_valid), 32'd0);

    tick();
    x_operand_a = $urandom;
    x_operand_b = $urandom;
    #2;
    check("start_mult", 32'(md_ctrl_mult), 32'(!is_div));
    check("start_div", 32'(md_ctrl_div), 32'(is_div));
    check("start_opa", md_operand_a, a);
    check("start_opb", md_operand_b, b);
    check("start_stall", 32'(stall), 32'd1);

    for (int unsigned i = 1; i <= nbusy; i++) begin
      tick();
      md_ready     = (i == lat);
      md_exception = (i == lat) ? exc : 1'($urandom_range(0, 1));
      md_result    = (i == lat) ? res : 32'($urandom);
      mw_regwrite  = $urandom_range(0, 1);
      #2;
      check("busy_stall", 32'(stall), 32'd1);
      check("busy_nopulse", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
      check("busy_wbv", 32'(wb_valid), 32'd0);
      check("busy_opa", md_operand_a, a);
      check("busy_opb", md_operand_b, b);
    end

    for (int unsigned h = 0; h < hold; h++) begin
      tick();
      md_ready     = 1'b0;
      md_exception = 1'b0;
      md_result    = $urandom;
      mw_regwrite  = 1'b1;
      #2;
      check("hold_stall", 32'(stall), 32'd1);
      check("hold_wbv", 32'(wb_valid), 32'd0);
      check("hold_rd", 32'(wb_rd), 32'd0);
      check("hold_data", wb_data, 32'd0);
    end

    tick();
    md_ready    = 1'b0;
    mw_regwrite = 1'b0;
    md_result   = $urandom;
    #2;
    if (timeout || exc) begin
      exp_v    = 1'b1;
      exp_rd   = 5'd30;
      exp_data = is_div ? 32'd5 : 32'd4;
    end else begin
      exp_v    = (rd != 5'd0);
      exp_rd   = exp_v ? rd : 5'd0;
      exp_data = exp_v ? res : 32'd0;
    end
    check("wb_valid", 32'(wb_valid), 32'(exp_v));
    check("wb_rd", 32'(wb_rd), 32'(exp_rd));
    check("wb_data", wb_data, exp_data);
    check("wb_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    x_ir         = '0;
    x_operand_a  = '0;
    x_operand_b  = '0;
    flush        = 1'b0;
    mw_regwrite  = 1'b0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;

    #3;
    check_idle("rst");
    check("rst_rd", 32'(wb_rd), 32'd0);
    check("rst_opa", md_operand_a, 32'd0);
    check("rst_opb", md_operand_b, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #2;
    check_idle("post_rst");

    do_op(1'b0, 32'd6, 32'd7, 5'd5, 32, 1'b0, 32'd42, 0);
    do_op(1'b1, 32'd10, 32'd0, 5'd9, 5, 1'b1, 32'hdead, 0);

    tick();
    x_ir  = mk_md(1'b0, 5'd4);
    flush = 1'b1;
    #2;
    check("flush_stall", 32'(stall), 32'd0);
    tick();
    x_ir  = mk_other();
    flush = 1'b0;
    #2;
    check_idle("flush_after");

    do_op(1'b1, 32'd100, 32'd7, 5'd3, 8, 1'b0, 32'd14, 2);
    do_op(1'b0, 32'd3, 32'd3, 5'd7, 1000, 1'b0, 32'd0, 0);
    do_op(1'b0, 32'd2, 32'd2, 5'd0, 3, 1'b0, 32'd4, 1);
    do_op(1'b1, 32'd9, 32'd3, 5'd1, 40, 1'b0, 32'd3, 0);
    do_op(1'b0, 32'h7fffffff, 32'd2, 5'd2, 1, 1'b1, 32'd0, 0);

    // Reset in the middle of BUSY, then a stray md_ready.
    tick();
    x_ir        = mk_md(1'b0, 5'd12);
    x_operand_a = 32'd11;
    x_operand_b = 32'd13;
    flush       = 1'b0;
    mw_regwrite = 1'b0;
    tick();
    tick();
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_rd", 32'(wb_rd), 32'd0);
    check("async_rst_data", wb_data, 32'd0);
    check("async_rst_opa", md_operand_a, 32'd0);
    check("async_rst_opb", md_operand_b, 32'd0);
    tick();
    reset        = 1'b1;
    x_ir         = mk_other();
    md_ready     = 1'b1;
    md_exception = 1'b0;
    md_result    = 32'd123;
    #2;
    check_idle("stray_ready");
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      md_ready = 1'b0;
      #2;
      check_idle("stray_after");
    end
    do_op(1'b0, 32'd5, 32'd9, 5'd12, 4, 1'b0, 32'd45, 0);

    for (int unsigned n = 0; n < 40; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      do_op(1'($urandom_range(0, 1)), $urandom, $urandom, rd,
            $urandom_range(1, 45), ($urandom_range(0, 3) == 0), $urandom,
            $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    idle_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multdiv_stall_controller.md
Name: multdiv_stall_controller

Overview:
- Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.
- Detects mult/div in the execute stage and freezes the front end (PC, FD, DX) while the unit runs.
- Captures the result or exception and arbitrates one register-file write against the MW stage.
- Works alongside the XM latch, which already squashes mult/div instructions into bubbles.

Parameters:
- MAX_CYCLES, 40, busy cycles allowed before forced timeout exception
- CNT_W, 6, width of busy-cycle counter (must hold MAX_CYCLES)
- RSTATUS_REG, 30, destination register for exception codes
- MULT_EXC_CODE, 4, value written to rstatus on mult overflow/timeout
- DIV_EXC_CODE, 5, value written to rstatus on div exception/timeout

Ports:
- clock  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- x_ir  in  32  instruction currently in execute stage
- x_operand_a  in  32  bypassed rs operand in execute
- x_operand_b  in  32  bypassed rt operand in execute
- flush  in  1  execute-stage instruction is being squashed (taken branch/jump)
- mw_regwrite  in  1  MW stage writes register file this cycle
- md_ready  in  1  multdiv result valid (one-cycle pulse)
- md_exception  in  1  multdiv exception, qualified by md_ready
- md_result  in  32  multdiv result, qualified by md_ready
- md_ctrl_mult  out  1  one-cycle start pulse for multiply
- md_ctrl_div  out  1  one-cycle start pulse for divide
- md_operand_a  out  32  latched operand A, held stable from START until IDLE
- md_operand_b  out  32  latched operand B, held stable from START until IDLE
- stall  out  1  freeze PC/FD/DX write enables
- wb_valid  out  1  register-file write request from controller
- wb_rd  out  5  write destination
- wb_data  out  32  write data

Behaviour:
- Decode:
  - is_mult = opcode x_ir[31:27]==00000 and aluop x_ir[6:2]==00110.
  - is_div = same opcode, aluop==00111.
  - rd = x_ir[26:22].
- Reset (reset=0, asynchronous): state=IDLE, counter=0, all latched fields 0, all outputs 0.
  - Any operation in flight is abandoned; a later md_ready is ignored.
- IDLE:
  - stall = (is_mult|is_div) & ~flush, combinational, so execute is held at the same clock edge.
  - If launch condition is true: latch operands, rd, op type; next state START.
  - If flush=1: no launch, stall=0.
- START (1 cycle):
  - stall=1.
  - md_ctrl_mult or md_ctrl_div =1 per latched op, exactly this one cycle.
  - Counter cleared. Next state BUSY.
- BUSY:
  - stall=1; counter increments each cycle.
  - md_ready=1: latch result/exception; next state WB.
  - md_ready not sampled in START; the unit guarantees ≥1 cycle latency.
  - Counter==MAX_CYCLES-1 without md_ready: latch timeout as exception; next state WB.
- WB:
  - If mw_regwrite=1: stay in WB, stall=1, wb_valid=0 (MW has priority).
  - Else: wb_valid=1 for exactly this cycle, stall=0, next state IDLE.
    - The held instruction advances at this edge, so it is never relaunched.
  - Exception: wb_rd=RSTATUS_REG; wb_data=MULT_EXC_CODE or DIV_EXC_CODE by op.
  - Normal: wb_rd=latched rd, wb_data=md_result.
  - Normal result with rd==0: wb_valid stays 0, but the WB cycle still occurs.
- wb_rd/wb_data/md_operand_* are registered and stable whenever their qualifier is high; wb_rd/wb_data are 0 when wb_valid=0.
- Back-to-back mult/div: the second is seen in IDLE on the cycle after WB and launches normally; minimum gap between ctrl pulses is 3 + latency cycles.

Test Plan:
- mult 6*7, rd=5, md_ready 32 cycles after pulse, mw_regwrite=0:
  - md_ctrl_mult high exactly 1 cycle with operands 6/7.
  - stall high from launch through BUSY.
  - WB cycle: wb_valid=1, wb_rd=5, wb_data=42, stall=0.
- div 10/0, md_ready with md_exception=1 -> wb_valid=1, wb_rd=30, wb_data=5.
- mult in execute with flush=1 in IDLE -> no ctrl pulse, stall=0, state stays IDLE.
- div result ready while mw_regwrite=1 for 2 cycles:
  - WB held 2 cycles with stall=1, wb_valid=0.
  - wb_valid=1 on the third cycle.
- mult, md_ready never asserted, MAX_CYCLES=40 -> after 40 BUSY cycles: wb_valid=1, wb_rd=30, wb_data=4.
- reset asserted low mid-BUSY, md_ready pulsed afterward:
  - All outputs 0 immediately.
  - The later md_ready causes no write.
  - The next mult launches cleanly.
